// File: rtl/gpu_pkg.sv
// Shared constants for the raster/compositor/IRQ front-end: counter widths,
// register addresses, IRQ bit positions and default video timing.
package gpu_pkg;

  // Counter and coordinate widths
  localparam int CNT_W   = 10;
  localparam int COORD_W = 9;

  // CPU register window
  typedef enum logic [1:0] {
    REG_STATUS   = 2'd0,
    REG_ENABLE   = 2'd1,
    REG_LINE_CMP = 2'd2,
    REG_FRAME    = 2'd3
  } reg_addr_e;

  // IRQ source bit positions inside STATUS / ENABLE
  localparam int IRQ_VBS  = 0;
  localparam int IRQ_VBE  = 1;
  localparam int IRQ_LINE = 2;
  localparam int IRQ_N    = 3;

  // Default video timing (320x480 visible in a 400x525 raster)
  localparam int DEF_COLOR_BITS = 2;
  localparam int DEF_H_VISIBLE  = 320;
  localparam int DEF_H_FRONT    = 8;
  localparam int DEF_H_SYNC     = 48;
  localparam int DEF_H_BACK     = 24;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;

  // Map an active-high sync flag onto the pin level for a given polarity
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/gpu_timing_gen_m.sv
// Raster timing generator: horizontal/vertical counters plus the raw
// (active-high) sync flags, visible area, VRAM write window and fetch strobe.
module gpu_timing_gen_m
  import gpu_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int FETCH_LEN = 10
) (
  input  logic             clk_12_5875,
  input  logic             rst,
  output logic [CNT_W-1:0] o_hcounter,
  output logic [CNT_W-1:0] o_vcounter,
  output logic             o_hsync_act,
  output logic             o_vsync_act,
  output logic             o_visible,
  output logic             o_writable,
  output logic             o_fetch
);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] FETCH_C    = CNT_W'(FETCH_LEN);

  logic [CNT_W-1:0] r_hcounter;
  logic [CNT_W-1:0] r_vcounter;

  // Pixel counter wraps each line; line counter steps on the pixel wrap
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_hcounter <= '0;
      r_vcounter <= '0;
    end else if (r_hcounter == H_LAST) begin
      r_hcounter <= '0;
      r_vcounter <= (r_vcounter == V_LAST) ? '0 : r_vcounter + 1'b1;
    end else begin
      r_hcounter <= r_hcounter + 1'b1;
    end
  end

  assign o_hcounter  = r_hcounter;
  assign o_vcounter  = r_vcounter;
  assign o_hsync_act = (r_hcounter >= H_SYNC_BEG) && (r_hcounter < H_SYNC_END);
  assign o_vsync_act = (r_vcounter >= V_SYNC_BEG) && (r_vcounter < V_SYNC_END);
  assign o_visible   = (r_hcounter < H_VIS_C) && (r_vcounter < V_VIS_C);
  assign o_writable  = (r_vcounter >= V_VIS_C);
  assign o_fetch     = (r_vcounter == '0) && (r_hcounter < FETCH_C);

endmodule

// File: rtl/gpu_raster_ctrl_m.sv
// Raster front-end top: pixel coordinates, fg-over-bg compositing with a
// sync-matched delay pipe, and the CPU-visible IRQ/register window.
module gpu_raster_ctrl_m
  import gpu_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_POL   = 0,
  parameter int ACTIVE_W   = 256,
  parameter int ACTIVE_H   = 240,
  parameter int X_OFFSET   = 32,
  parameter int Y_SHIFT    = 1,
  parameter int PIPE_DELAY = 1,
  parameter int FETCH_LEN  = 10
) (
  input  logic                  clk_12_5875,
  input  logic                  rst,
  input  logic                  cpu_clk_enable,
  input  logic                  reg_select,
  input  logic [1:0]            reg_addr,
  input  logic                  write_enable,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic [COLOR_BITS-1:0] fg_r,
  input  logic [COLOR_BITS-1:0] fg_g,
  input  logic [COLOR_BITS-1:0] fg_b,
  input  logic                  fg_valid,
  input  logic [COLOR_BITS-1:0] bg_r,
  input  logic [COLOR_BITS-1:0] bg_g,
  input  logic [COLOR_BITS-1:0] bg_b,
  output logic [8:0]            current_x,
  output logic [8:0]            current_y,
  output logic                  writable,
  output logic [COLOR_BITS-1:0] r,
  output logic [COLOR_BITS-1:0] g,
  output logic [COLOR_BITS-1:0] b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  controller_start_fetch,
  output logic                  irq
);

  localparam logic                  POL       = 1'(SYNC_POL);
  localparam int                    PIPE_W    = 3 * COLOR_BITS + 2;
  localparam logic [PIPE_W-1:0]     PIPE_RST  = {~POL, ~POL, {(3 * COLOR_BITS){1'b0}}};
  localparam logic [CNT_W-1:0]      X_BEG     = CNT_W'(X_OFFSET);
  localparam logic [CNT_W-1:0]      X_END     = CNT_W'(X_OFFSET + ACTIVE_W);
  localparam logic [CNT_W-1:0]      V_VIS_C   = CNT_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0]    X_OFF_C   = COORD_W'(X_OFFSET);
  localparam logic [COORD_W-1:0]    ACT_H_C   = COORD_W'(ACTIVE_H);
  // Low vcounter bits that must be zero for a line-match (none when Y_SHIFT is 0)
  localparam logic [CNT_W-1:0]      Y_MASK    = CNT_W'((1 << Y_SHIFT) - 1);

  logic [CNT_W-1:0]      w_hcounter;
  logic [CNT_W-1:0]      w_vcounter;
  logic                  w_hs_act;
  logic                  w_vs_act;
  logic                  w_visible;
  logic                  w_writable;
  logic                  w_fetch;
  logic [COORD_W-1:0]    w_cur_x;
  logic [COORD_W-1:0]    w_cur_y;
  logic                  w_drawing;
  logic [COLOR_BITS-1:0] w_pix_r;
  logic [COLOR_BITS-1:0] w_pix_g;
  logic [COLOR_BITS-1:0] w_pix_b;
  logic [PIPE_W-1:0]     w_chain [PIPE_DELAY+1];
  logic                  w_line_start;
  logic [IRQ_N-1:0]      w_event;
  logic                  w_cpu_wr;
  logic [IRQ_N-1:0]      w_status_clr;

  logic                  r_after_rst;
  logic [IRQ_N-1:0]      r_status;
  logic [IRQ_N-1:0]      r_enable;
  logic [7:0]            r_line_cmp;
  logic [7:0]            r_frame;
  logic                  r_irq;

  gpu_timing_gen_m #(
    .H_VISIBLE (H_VISIBLE),
    .H_FRONT   (H_FRONT),
    .H_SYNC    (H_SYNC),
    .H_BACK    (H_BACK),
    .V_VISIBLE (V_VISIBLE),
    .V_FRONT   (V_FRONT),
    .V_SYNC    (V_SYNC),
    .V_BACK    (V_BACK),
    .FETCH_LEN (FETCH_LEN)
  ) u_timing (
    .clk_12_5875 (clk_12_5875),
    .rst         (rst),
    .o_hcounter  (w_hcounter),
    .o_vcounter  (w_vcounter),
    .o_hsync_act (w_hs_act),
    .o_vsync_act (w_vs_act),
    .o_visible   (w_visible),
    .o_writable  (w_writable),
    .o_fetch     (w_fetch)
  );

  assign w_cur_x                = w_hcounter[COORD_W-1:0] - X_OFF_C;
  assign w_cur_y                = COORD_W'(w_vcounter >> Y_SHIFT);
  assign current_x              = w_cur_x;
  assign current_y              = w_cur_y;
  assign writable               = w_writable;
  assign controller_start_fetch = w_fetch;

  assign w_drawing = w_visible && (w_hcounter >= X_BEG) && (w_hcounter < X_END)
                     && (w_cur_y < ACT_H_C);

  // Compositor: opaque foreground wins over background; black outside the drawn area
  always_comb begin
    w_pix_r = '0;
    w_pix_g = '0;
    w_pix_b = '0;
    if (w_drawing) begin
      if (fg_valid) begin
        w_pix_r = fg_r;
        w_pix_g = fg_g;
        w_pix_b = fg_b;
      end else begin
        w_pix_r = bg_r;
        w_pix_g = bg_g;
        w_pix_b = bg_b;
      end
    end
  end

  // Colour and syncs travel together so they stay aligned at the DAC
  assign w_chain[0] = {sync_level(w_hs_act, POL), sync_level(w_vs_act, POL),
                       w_pix_r, w_pix_g, w_pix_b};

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DELAY; gi++) begin : g_pipe
      logic [PIPE_W-1:0] r_stage;
      // One delay stage; resets to black with both syncs inactive
      always_ff @(posedge clk_12_5875) begin
        if (rst) r_stage <= PIPE_RST;
        else     r_stage <= w_chain[gi];
      end
      assign w_chain[gi+1] = r_stage;
    end
  endgenerate

  assign {hsync, vsync, r, g, b} = w_chain[PIPE_DELAY];

  // Flags the first cycle out of reset so the (0,0) position does not fire events
  always_ff @(posedge clk_12_5875) begin
    if (rst) r_after_rst <= 1'b1;
    else     r_after_rst <= 1'b0;
  end

  assign w_line_start = (w_hcounter == '0) && !r_after_rst;

  // Single-cycle IRQ events, all sampled at the start of a line
  always_comb begin
    w_event = '0;
    if (w_line_start) begin
      w_event[IRQ_VBS]  = (w_vcounter == V_VIS_C);
      w_event[IRQ_VBE]  = (w_vcounter == '0);
      w_event[IRQ_LINE] = (w_cur_y == {1'b0, r_line_cmp})
                          && ((w_vcounter & Y_MASK) == '0)
                          && (w_vcounter < V_VIS_C);
    end
  end

  assign w_cpu_wr     = reg_select && write_enable && cpu_clk_enable;
  assign w_status_clr = (w_cpu_wr && (reg_addr == REG_STATUS)) ? data_in[IRQ_N-1:0] : '0;

  // Register file: sticky W1C status (set beats clear), enable, compare line, frame count, irq
  always_ff @(posedge clk_12_5875) begin
    if (rst) begin
      r_status   <= '0;
      r_enable   <= '0;
      r_line_cmp <= '0;
      r_frame    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_status_clr) | w_event;
      r_irq    <= |(r_status & r_enable);
      if (w_event[IRQ_VBS]) r_frame <= r_frame + 8'd1;
      if (w_cpu_wr && (reg_addr == REG_ENABLE))   r_enable   <= data_in[IRQ_N-1:0];
      if (w_cpu_wr && (reg_addr == REG_LINE_CMP)) r_line_cmp <= data_in;
    end
  end

  assign irq = r_irq;

  // Read mux; the bus reads zero when the window is not selected
  always_comb begin
    data_out = 8'h00;
    if (reg_select) begin
      case (reg_addr_e'(reg_addr))
        REG_STATUS:   data_out = {4'b0000, w_writable, r_status};
        REG_ENABLE:   data_out = {5'b00000, r_enable};
        REG_LINE_CMP: data_out = r_line_cmp;
        REG_FRAME:    data_out = r_frame;
        default:      data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_raster_ctrl_m.sv
// Scoreboard bench for gpu_raster_ctrl_m: a stimulus process drives random
// cycles and queues the outputs a position/frame-based reference model
// predicts; a monitor on the falling edge pops and compares every cycle.
module tb_gpu_raster_ctrl_m;

  localparam int CB = 2;
  localparam int HV = 8, HF = 1, HS = 2, HB = 1;
  localparam int VV = 6, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int POL = 0;
  localparam int AW = 4, AH = 2, XO = 2, YS = 1, PD = 2, FL = 3;
  localparam int PW = 3 * CB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_clk_enable = 1'b0;
  logic          reg_select = 1'b0;
  logic [1:0]    reg_addr = 2'd0;
  logic          write_enable = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic [CB-1:0] fg_r = '0, fg_g = '0, fg_b = '0;
  logic          fg_valid = 1'b0;
  logic [CB-1:0] bg_r = '0, bg_g = '0, bg_b = '0;
  logic [8:0]    current_x, current_y;
  logic          writable;
  logic [CB-1:0] r, g, b;
  logic          hsync, vsync, controller_start_fetch, irq;

  gpu_raster_ctrl_m #(
    .COLOR_BITS(CB), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL),
    .ACTIVE_W(AW), .ACTIVE_H(AH), .X_OFFSET(XO), .Y_SHIFT(YS),
    .PIPE_DELAY(PD), .FETCH_LEN(FL)
  ) dut (
    .clk_12_5875(clk), .rst(rst), .cpu_clk_enable(cpu_clk_enable),
    .reg_select(reg_select), .reg_addr(reg_addr), .write_enable(write_enable),
    .data_in(data_in), .data_out(data_out),
    .fg_r(fg_r), .fg_g(fg_g), .fg_b(fg_b), .fg_valid(fg_valid),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .current_x(current_x), .current_y(current_y), .writable(writable),
    .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
    .controller_start_fetch(controller_start_fetch), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    dout;
    logic [8:0]    cx;
    logic [8:0]    cy;
    logic          wr;
    logic          fetch;
    logic          irq;
    logic          hs;
    logic          vs;
    logic [PW-1:0] rgb;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: cycles since reset plus the register contents
  int            m_t = 0;
  logic [2:0]    m_status = '0, m_enable = '0;
  logic [7:0]    m_line = '0, m_frame = '0;
  logic          m_irq = 1'b0, m_after_rst = 1'b0, m_valid = 1'b0;
  logic [PW+1:0] m_pipe[$];

  function automatic int m_h();
    return m_t % HT;
  endfunction

  function automatic int m_v();
    return (m_t / HT) % VT;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queue
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("data_out", 32'(data_out), 32'(e.dout));
      check("current_x", 32'(current_x), 32'(e.cx));
      check("current_y", 32'(current_y), 32'(e.cy));
      check("writable", 32'(writable), 32'(e.wr));
      check("fetch", 32'(controller_start_fetch), 32'(e.fetch));
      check("irq", 32'(irq), 32'(e.irq));
      check("hsync", 32'(hsync), 32'(e.hs));
      check("vsync", 32'(vsync), 32'(e.vs));
      check("rgb", 32'({r, g, b}), 32'(e.rgb));
    end
  end

  // Drive one cycle, queue its expected outputs, advance the model across the edge
  task automatic step(input logic rs, input logic sel, input logic [1:0] addr,
                      input logic we, input logic ce, input logic [7:0] din,
                      input logic fv, input logic [PW-1:0] fg, input logic [PW-1:0] bg);
    int h, v, cx, cy;
    obs_t e;
    logic [2:0] ev, clr;
    logic drawing, hsa, vsa, wr_hit;
    logic [PW-1:0] pix;
    rst = rs; reg_select = sel; reg_addr = addr; write_enable = we;
    cpu_clk_enable = ce; data_in = din; fg_valid = fv;
    {fg_r, fg_g, fg_b} = fg;
    {bg_r, bg_g, bg_b} = bg;
    h = m_h();
    v = m_v();
    cx = (h - XO) & 511;
    cy = v >> YS;
    if (m_valid) begin
      if (!sel) e.dout = 8'h00;
      else case (addr)
        2'd0:    e.dout = {4'b0000, (v >= VV), m_status};
        2'd1:    e.dout = {5'b00000, m_enable};
        2'd2:    e.dout = m_line;
        default: e.dout = m_frame;
      endcase
      e.cx = 9'(cx);
      e.cy = 9'(cy);
      e.wr = (v >= VV);
      e.fetch = (v == 0) && (h < FL);
      e.irq = m_irq;
      {e.hs, e.vs, e.rgb} = m_pipe[0];
      exp_q.push_back(e);
    end
    if (rs) begin
      m_t = 0; m_status = '0; m_enable = '0; m_line = '0; m_frame = '0;
      m_irq = 1'b0; m_after_rst = 1'b1; m_valid = 1'b1;
      m_pipe.delete();
      repeat (PD) m_pipe.push_back({(POL == 0), (POL == 0), {PW{1'b0}}});
    end else begin
      ev = '0;
      if (h == 0 && !m_after_rst) begin
        ev[0] = (v == VV);
        ev[1] = (v == 0);
        ev[2] = (cy == m_line) && (v % (1 << YS) == 0) && (v < VV);
      end
      wr_hit = sel && we && ce;
      clr = (wr_hit && addr == 2'd0) ? din[2:0] : 3'b000;
      m_irq = |(m_status & m_enable);
      if (wr_hit && addr == 2'd1) m_enable = din[2:0];
      if (wr_hit && addr == 2'd2) m_line = din;
      if (ev[0]) m_frame = m_frame + 8'd1;
      m_status = (m_status & ~clr) | ev;
      drawing = (h < HV) && (v < VV) && (h >= XO) && (h < XO + AW) && (cy < AH);
      pix = drawing ? (fv ? fg : bg) : '0;
      hsa = (h >= HV + HF) && (h < HV + HF + HS);
      vsa = (v >= VV + VF) && (v < VV + VF + VS);
      void'(m_pipe.pop_front());
      m_pipe.push_back({(POL != 0) ? hsa : !hsa, (POL != 0) ? vsa : !vsa, pix});
      m_t++;
      m_after_rst = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // One random cycle; wr_pct is the percentage chance of a CPU write attempt
  task automatic rand_cycle(input int wr_pct);
    logic [1:0] a;
    logic [7:0] d;
    logic w;
    a = 2'($urandom_range(0, 3));
    w = ($urandom_range(0, 99) < wr_pct);
    d = (a == 2'd2) ? 8'($urandom_range(0, 6)) : 8'($urandom);
    step(1'b0, 1'($urandom_range(0, 1)) | w, a, w, ($urandom_range(0, 3) != 0), d,
         1'($urandom), PW'($urandom), PW'($urandom));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, '0, '0);

    // Free run with fixed fg/bg colours and reads only
    repeat (2 * HT * VT)
      step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, 1'b1, 8'h00,
           1'($urandom), PW'(6'h3F), PW'(6'h15));

    // Random CPU traffic
    repeat (30 * HT * VT) rand_cycle(8);

    // Enable everything, then clear VBE in the exact cycle the VBE event fires
    step(1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 8'h07, 1'b0, '0, '0);
    for (int i = 0; i < HT * VT + 1 && !(m_h() == 0 && m_v() == 0); i++) rand_cycle(0);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 8'h02, 1'b0, '0, '0);
    repeat (3) step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, '0, '0);
    // Clear attempt without the bus enable must be ignored
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 8'h07, 1'b0, '0, '0);
    repeat (3) step(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, '0, '0);
    step(1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 8'h07, 1'b0, '0, '0);
    repeat (2 * HT * VT) rand_cycle(4);

    // Mid-frame reset, then carry on
    for (int i = 0; i < HT * VT + 1 && !(m_v() == 4 && m_h() == 5); i++) rand_cycle(4);
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, '0, '0);
    repeat (3 * HT * VT) rand_cycle(6);

    // Long run so the frame counter wraps past 255
    repeat (260 * HT * VT) rand_cycle(2);

    @(negedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
